// File: rtl/rv_dmem_responder.sv
// rv_dmem_responder: single-outstanding data-memory target with configurable wait states,
// byte-lane stores, sign/zero-extended loads and access-error reporting.
module rv_dmem_responder #(
   parameter int          MEM_DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
   parameter int          WAIT_CYCLES     = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        req_wr_en,
   input  logic [3:0]  req_byte_en,
   input  logic        req_is_signed,
   input  logic [31:0] req_wr_data,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rd_data,
   output logic        rsp_err
);
   localparam int AW = (MEM_DEPTH_WORDS > 1) ? $clog2(MEM_DEPTH_WORDS) : 1;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, wdata_q, rdata_q, rdata_d;
   logic [3:0]  be_q;
   logic        wr_q, sgn_q, err_q, err_d;
   logic [31:0] mem [MEM_DEPTH_WORDS];
   logic        accept, commit, c_wr, c_sgn, err;
   logic [31:0] c_addr, c_wdata, wsh, rsh, ld;
   logic [31:2] off;
   logic [3:0]  c_be, mask;
   logic [1:0]  lane;
   logic [AW-1:0] widx;
   assign req_ready   = state_q == IDLE;
   assign rsp_valid   = state_q == RESP;
   assign rsp_rd_data = rdata_q;
   assign rsp_err     = err_q;
   assign accept = req_ready && req_valid;
   // zero wait states commit straight from the live request at the accept edge
   assign commit  = rst && ((WAIT_CYCLES == 0) ? accept : (state_q == WAIT && cnt_q == 4'd0));
   assign c_addr  = (WAIT_CYCLES == 0) ? req_addr      : addr_q;
   assign c_wdata = (WAIT_CYCLES == 0) ? req_wr_data   : wdata_q;
   assign c_be    = (WAIT_CYCLES == 0) ? req_byte_en   : be_q;
   assign c_wr    = (WAIT_CYCLES == 0) ? req_wr_en     : wr_q;
   assign c_sgn   = (WAIT_CYCLES == 0) ? req_is_signed : sgn_q;
   assign lane = c_addr[1:0];
   assign off  = c_addr[31:2] - BASE_ADDR[31:2];
   assign widx = off[AW+1:2];
   assign mask = c_be << lane;
   assign err  = !(c_be inside {4'b0001, 4'b0011, 4'b1111}) || (c_be == 4'b0011 && c_addr[0]) ||
                 (c_be == 4'b1111 && lane != 2'd0) || c_addr < BASE_ADDR ||
                 {2'b00, off} >= 32'(MEM_DEPTH_WORDS);
   assign wsh = c_wdata << {lane, 3'b000};
   assign rsh = mem[widx] >> {lane, 3'b000};
   assign ld  = c_be == 4'b0001 ? {{24{c_sgn & rsh[7]}}, rsh[7:0]} :
                c_be == 4'b0011 ? {{16{c_sgn & rsh[15]}}, rsh[15:0]} : rsh;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = commit ? ((err || c_wr) ? 32'd0 : ld) : rdata_q;
      err_d   = commit ? err : err_q;
      case (state_q)
         IDLE: if (req_valid) begin
            state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
         end
         WAIT: begin
            cnt_d   = cnt_q - 4'd1;
            state_d = (cnt_q == 4'd0) ? RESP : WAIT;
         end
         RESP: state_d = rsp_ready ? IDLE : RESP;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         be_q    <= 4'd0;
         wr_q    <= 1'b0;
         sgn_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wr_data;
            be_q    <= req_byte_en;
            wr_q    <= req_wr_en;
            sgn_q   <= req_is_signed;
         end
      end
   end
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++)
         if (commit && c_wr && !err && mask[i]) mem[widx][8*i +: 8] <= wsh[8*i +: 8];
   end
endmodule

// File: tb/tb_rv_dmem_responder.sv
// tb_rv_dmem_responder: directed checks on a zero-wait instance (index 0) and a three-wait instance (index 1).
module tb_rv_dmem_responder;
   logic clk = 1'b0;
   logic [1:0] rst, req_valid, req_ready, req_wr_en, req_is_signed, rsp_valid, rsp_ready, rsp_err;
   logic [1:0][31:0] req_addr, req_wr_data, rsp_rd_data;
   logic [1:0][3:0] req_byte_en;
   int vec = 0;
   int miss = 0;
   logic [31:0] rd;
   logic er;
   int lat;

   always #5 clk = ~clk;

   rv_dmem_responder #(.MEM_DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) u0 (
      .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_addr(req_addr[0]), .req_wr_en(req_wr_en[0]), .req_byte_en(req_byte_en[0]),
      .req_is_signed(req_is_signed[0]), .req_wr_data(req_wr_data[0]), .rsp_valid(rsp_valid[0]),
      .rsp_ready(rsp_ready[0]), .rsp_rd_data(rsp_rd_data[0]), .rsp_err(rsp_err[0]));

   rv_dmem_responder #(.MEM_DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(3)) u3 (
      .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_addr(req_addr[1]), .req_wr_en(req_wr_en[1]), .req_byte_en(req_byte_en[1]),
      .req_is_signed(req_is_signed[1]), .req_wr_data(req_wr_data[1]), .rsp_valid(rsp_valid[1]),
      .rsp_ready(rsp_ready[1]), .rsp_rd_data(rsp_rd_data[1]), .rsp_err(rsp_err[1]));

   task automatic drive(input int d, input logic wr, input logic [3:0] be, input logic sgn,
                        input logic [31:0] a, input logic [31:0] wd);
      req_valid[d] = 1'b1;
      req_wr_en[d] = wr;
      req_byte_en[d] = be;
      req_is_signed[d] = sgn;
      req_addr[d] = a;
      req_wr_data[d] = wd;
   endtask

   // full transaction from IDLE; lat = cycles from accept edge to first rsp_valid, -1 on timeout
   task automatic xact(input int d, input logic wr, input logic [3:0] be, input logic sgn,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] r, output logic e, output int l);
      drive(d, wr, be, sgn, a, wd);
      @(posedge clk);
      #1 req_valid[d] = 1'b0;
      l = 1;
      while (!rsp_valid[d] && l < 20) begin
         @(posedge clk);
         #1 l++;
      end
      if (!rsp_valid[d]) l = -1;
      r = rsp_rd_data[d];
      e = rsp_err[d];
      rsp_ready[d] = 1'b1;
      @(posedge clk);
      #1 rsp_ready[d] = 1'b0;
   endtask

   task automatic test_reset();
      for (int d = 0; d < 2; d++) begin
         vec++; if (req_ready[d] !== 1'b1) begin miss++; $display("FAIL reset_req_ready[%0d] got=%b exp=1", d, req_ready[d]); end
         vec++; if (rsp_valid[d] !== 1'b0) begin miss++; $display("FAIL reset_rsp_valid[%0d] got=%b exp=0", d, rsp_valid[d]); end
         vec++; if (rsp_rd_data[d] !== 32'h0) begin miss++; $display("FAIL reset_rd_data[%0d] got=%h exp=0", d, rsp_rd_data[d]); end
         vec++; if (rsp_err[d] !== 1'b0) begin miss++; $display("FAIL reset_err[%0d] got=%b exp=0", d, rsp_err[d]); end
      end
   endtask

   task automatic test_word();
      xact(0, 1'b1, 4'b1111, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat);
      vec++; if (lat !== 1) begin miss++; $display("FAIL sw_latency got=%0d exp=1", lat); end
      vec++; if (rd !== 32'h0 || er !== 1'b0) begin miss++; $display("FAIL sw_rsp got=%h/%b exp=0/0", rd, er); end
      xact(0, 1'b0, 4'b1111, 1'b0, 32'h10, 32'h0, rd, er, lat);
      vec++; if (lat !== 1) begin miss++; $display("FAIL lw_latency got=%0d exp=1", lat); end
      vec++; if (rd !== 32'hDEADBEEF) begin miss++; $display("FAIL lw_data got=%h exp=deadbeef", rd); end
      vec++; if (er !== 1'b0) begin miss++; $display("FAIL lw_err got=%b exp=0", er); end
   endtask

   task automatic test_extend();
      xact(0, 1'b1, 4'b1111, 1'b0, 32'h20, 32'h80FF7F01, rd, er, lat);
      xact(0, 1'b0, 4'b0001, 1'b1, 32'h23, 32'h0, rd, er, lat);
      vec++; if (rd !== 32'hFFFFFF80) begin miss++; $display("FAIL lb got=%h exp=ffffff80", rd); end
      xact(0, 1'b0, 4'b0001, 1'b0, 32'h23, 32'h0, rd, er, lat);
      vec++; if (rd !== 32'h00000080) begin miss++; $display("FAIL lbu got=%h exp=00000080", rd); end
      xact(0, 1'b0, 4'b0011, 1'b1, 32'h22, 32'h0, rd, er, lat);
      vec++; if (rd !== 32'hFFFF80FF) begin miss++; $display("FAIL lh got=%h exp=ffff80ff", rd); end
      xact(0, 1'b0, 4'b0011, 1'b0, 32'h20, 32'h0, rd, er, lat);
      vec++; if (rd !== 32'h00007F01) begin miss++; $display("FAIL lhu got=%h exp=00007f01", rd); end
      xact(0, 1'b0, 4'b0001, 1'b1, 32'h20, 32'h0, rd, er, lat);
      vec++; if (rd !== 32'h00000001) begin miss++; $display("FAIL lb_pos got=%h exp=00000001", rd); end
   endtask

   task automatic test_partial();
      xact(0, 1'b1, 4'b1111, 1'b0, 32'h20, 32'h11223344, rd, er, lat);
      xact(0, 1'b1, 4'b0001, 1'b0, 32'h21, 32'h000000AA, rd, er, lat);
      xact(0, 1'b0, 4'b1111, 1'b0, 32'h20, 32'h0, rd, er, lat);
      vec++; if (rd !== 32'h1122AA44) begin miss++; $display("FAIL sb_merge got=%h exp=1122aa44", rd); end
      xact(0, 1'b1, 4'b0011, 1'b0, 32'h22, 32'h0000BEEF, rd, er, lat);
      xact(0, 1'b0, 4'b1111, 1'b0, 32'h20, 32'h0, rd, er, lat);
      vec++; if (rd !== 32'hBEEFAA44) begin miss++; $display("FAIL sh_merge got=%h exp=beefaa44", rd); end
   endtask

   task automatic test_errors();
      xact(0, 1'b0, 4'b1111, 1'b0, 32'h02, 32'h0, rd, er, lat);
      vec++; if (er !== 1'b1 || rd !== 32'h0) begin miss++; $display("FAIL lw_misaligned got=%h/%b exp=0/1", rd, er); end
      xact(0, 1'b1, 4'b1111, 1'b0, 32'h04, 32'hCAFEF00D, rd, er, lat);
      xact(0, 1'b1, 4'b0011, 1'b0, 32'h05, 32'h00001234, rd, er, lat);
      vec++; if (er !== 1'b1 || rd !== 32'h0) begin miss++; $display("FAIL sh_misaligned got=%h/%b exp=0/1", rd, er); end
      xact(0, 1'b0, 4'b1111, 1'b0, 32'h04, 32'h0, rd, er, lat);
      vec++; if (rd !== 32'hCAFEF00D || er !== 1'b0) begin miss++; $display("FAIL sh_suppressed got=%h/%b exp=cafef00d/0", rd, er); end
      xact(0, 1'b0, 4'b1111, 1'b0, 32'h1000, 32'h0, rd, er, lat);
      vec++; if (er !== 1'b1 || rd !== 32'h0) begin miss++; $display("FAIL out_of_range got=%h/%b exp=0/1", rd, er); end
      xact(0, 1'b0, 4'b1111, 1'b0, 32'h0FFC, 32'h0, rd, er, lat);
      vec++; if (er !== 1'b0) begin miss++; $display("FAIL last_word_err got=%b exp=0", er); end
      xact(0, 1'b0, 4'b0111, 1'b0, 32'h04, 32'h0, rd, er, lat);
      vec++; if (er !== 1'b1 || rd !== 32'h0) begin miss++; $display("FAIL bad_byte_en got=%h/%b exp=0/1", rd, er); end
   endtask

   task automatic test_wait_stall();
      xact(1, 1'b1, 4'b1111, 1'b0, 32'h40, 32'h5A5A0001, rd, er, lat);
      vec++; if (lat !== 4) begin miss++; $display("FAIL wait_sw_latency got=%0d exp=4", lat); end
      drive(1, 1'b0, 4'b1111, 1'b0, 32'h40, 32'h0);
      @(posedge clk);
      #1 req_valid[1] = 1'b0;
      lat = 1;
      while (!rsp_valid[1] && lat < 20) begin
         vec++; if (req_ready[1] !== 1'b0) begin miss++; $display("FAIL wait_req_ready got=%b exp=0", req_ready[1]); end
         @(posedge clk);
         #1 lat++;
      end
      vec++; if (lat !== 4 || rsp_valid[1] !== 1'b1) begin miss++; $display("FAIL wait_lw_latency got=%0d exp=4", lat); end
      for (int i = 0; i < 5; i++) begin
         vec++; if (rsp_valid[1] !== 1'b1 || rsp_rd_data[1] !== 32'h5A5A0001 || req_ready[1] !== 1'b0) begin
            miss++; $display("FAIL stall_hold[%0d] valid=%b rd=%h ready=%b exp 1/5a5a0001/0", i, rsp_valid[1], rsp_rd_data[1], req_ready[1]);
         end
         @(posedge clk);
         #1;
      end
      rsp_ready[1] = 1'b1;
      @(posedge clk);
      #1 rsp_ready[1] = 1'b0;
      vec++; if (rsp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1) begin miss++; $display("FAIL after_handshake valid=%b ready=%b exp 0/1", rsp_valid[1], req_ready[1]); end
      vec++; if (rsp_rd_data[1] !== 32'h5A5A0001) begin miss++; $display("FAIL rd_kept got=%h exp=5a5a0001", rsp_rd_data[1]); end
   endtask

   task automatic test_reset_mid_wait();
      xact(1, 1'b1, 4'b1111, 1'b0, 32'h50, 32'h11111111, rd, er, lat);
      xact(1, 1'b0, 4'b1111, 1'b0, 32'h50, 32'h0, rd, er, lat);
      vec++; if (rd !== 32'h11111111) begin miss++; $display("FAIL pre_reset_load got=%h exp=11111111", rd); end
      drive(1, 1'b1, 4'b1111, 1'b0, 32'h50, 32'h22222222);
      @(posedge clk);
      #1 req_valid[1] = 1'b0;
      @(posedge clk);
      #1 rst[1] = 1'b0;
      #1;
      vec++; if (req_ready[1] !== 1'b1 || rsp_valid[1] !== 1'b0 || rsp_rd_data[1] !== 32'h0 || rsp_err[1] !== 1'b0) begin
         miss++; $display("FAIL mid_wait_reset ready=%b valid=%b rd=%h err=%b exp 1/0/0/0", req_ready[1], rsp_valid[1], rsp_rd_data[1], rsp_err[1]);
      end
      @(posedge clk);
      @(negedge clk) rst[1] = 1'b1;
      @(posedge clk);
      #1;
      xact(1, 1'b0, 4'b1111, 1'b0, 32'h50, 32'h0, rd, er, lat);
      vec++; if (rd !== 32'h11111111 || er !== 1'b0) begin miss++; $display("FAIL abandoned_store got=%h/%b exp=11111111/0", rd, er); end
   endtask

   initial begin
      rst = 2'b00;
      req_valid = '0;
      req_wr_en = '0;
      req_is_signed = '0;
      rsp_ready = '0;
      req_addr = '0;
      req_wr_data = '0;
      req_byte_en = '0;
      #2;
      test_reset();
      @(posedge clk);
      @(posedge clk);
      #1 rst = 2'b11;
      test_word();
      test_extend();
      test_partial();
      test_errors();
      test_wait_stall();
      test_reset_mid_wait();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end
endmodule

// File: doc/rv_dmem_responder.md
Name: rv_dmem_responder

Overview:
- Data-memory responder: the target end of the core's data-memory request interface (wr_en / byte_en / is_signed / address / write data).
- Accepts one request at a time over a valid/ready handshake, applies a configurable number of wait states, commits writes, and returns load data over a valid/ready response channel.
- Used as the data-side memory model and slave for the 5-stage core, and as the building block for later slow-memory/bus experiments.

Parameters:
- MEM_DEPTH_WORDS, 1024: number of 32-bit words of storage; word index = (req_addr - BASE_ADDR) >> 2.
- BASE_ADDR, 32'h0000_0000: first byte address served.
- WAIT_CYCLES, 0: extra cycles between request accept and the commit/response; legal range 0..15.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- req_valid  in  1  request present
- req_ready  out  1  responder can accept
- req_addr  in  32  byte address
- req_wr_en  in  1  1 = store, 0 = load
- req_byte_en  in  4  access size, unshifted: 4'b0001 byte, 4'b0011 half, 4'b1111 word
- req_is_signed  in  1  load sign-extension select
- req_wr_data  in  32  store data, right-aligned
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rd_data  out  32  load result, right-aligned and extended; 0 for stores and errors
- rsp_err  out  1  access error flag

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, wait counter=0, rsp_valid=0, rsp_rd_data=0, rsp_err=0, req_ready=1.
  - Storage contents are not reset.
  - Reset during WAIT or RESP abandons the transaction. A store whose commit edge has not occurred is never written.
- FSM states IDLE, WAIT, RESP. req_ready = (state==IDLE). One outstanding transaction; no pipelining.
- IDLE:
  - Accept on a clock edge with req_valid && req_ready. All req_* fields are latched at that edge.
  - WAIT_CYCLES==0: go straight to RESP, and commit at the accept edge.
  - Otherwise: go to WAIT with counter = WAIT_CYCLES-1.
- WAIT: counter decrements each cycle. At the edge where counter==0: commit and go to RESP.
- Commit edge:
  - Stores write the storage.
  - Loads capture the read value into rsp_rd_data.
  - rsp_err is registered.
  - Result: first cycle with rsp_valid=1 is 1+WAIT_CYCLES cycles after the accept edge.
- RESP:
  - rsp_valid=1.
  - rsp_rd_data and rsp_err are held stable until rsp_ready=1.
  - On an edge with rsp_valid && rsp_ready: go to IDLE and drop rsp_valid. rsp_rd_data and rsp_err keep their last values.
  - A new request is accepted no earlier than the cycle after the response handshake.
- Lane mapping: lane = req_addr[1:0]; effective byte mask = req_byte_en << lane.
  - Store: data byte i goes to lane+i for each enabled byte; unenabled bytes are unchanged.
  - Load: enabled lanes are shifted down to bit 0.
    - is_signed=1: sign-extend from bit 7 (byte) or bit 15 (half).
    - is_signed=0: zero-extend.
    - Word loads are unaffected by is_signed.
- Errors; on any error the store is suppressed, rsp_rd_data=0 and rsp_err=1:
  - req_byte_en not one of 0001/0011/1111;
  - half access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - addr < BASE_ADDR;
  - word index >= MEM_DEPTH_WORDS.
- Simultaneous events:
  - req_valid while not IDLE is ignored; the requester must hold the request.
  - rsp_ready asserted outside RESP has no effect.
  - Read after write to the same word returns the new data, since the write has committed before the next accept.

Test Plan:
- WAIT_CYCLES=0: store word 0xDEADBEEF @0x10, then load word @0x10 -> each rsp_valid exactly 1 cycle after accept; load rsp_rd_data=0xDEADBEEF, rsp_err=0.
- Byte/half extension after word 0x80FF7F01 @0x20:
  - lb @0x23 -> 0xFFFFFF80
  - lbu @0x23 -> 0x00000080
  - lh @0x22 -> 0xFFFF80FF
  - lhu @0x20 -> 0x00007F01
- Partial store: sb 0xAA @0x21 over 0x11223344 -> word load returns 0x1122AA44.
- Errors:
  - lw @0x02 -> rsp_err=1, rsp_rd_data=0.
  - sh @0x05 -> rsp_err=1, and a later word load shows memory unchanged.
  - Address 4*MEM_DEPTH_WORDS -> rsp_err=1.
- WAIT_CYCLES=3, rsp_ready low for 5 cycles:
  - rsp_valid rises 4 cycles after accept.
  - rsp_rd_data stays stable while rsp_valid=1 and rsp_ready=0.
  - req_ready=0 until the cycle after the response handshake.
- Reset mid-WAIT (WAIT_CYCLES=3) on a store:
  - Pulse rst low during WAIT -> outputs return to reset values immediately.
  - A subsequent load of that address shows the old data.
